// File: rtl/nvdla_periph_csb_bridge.sv
// Bridge from a periph-style slave port to the NVDLA CSB master interface.
// One transaction in flight; reads time out to ERR_DATA if CSB never answers.
module nvdla_periph_csb_bridge #(
  parameter int unsigned ID         = 10,
  parameter int unsigned RD_TIMEOUT = 1024,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          periph_req,
  output logic          periph_gnt,
  input  logic [31:0]   periph_add,
  input  logic          periph_wen,
  input  logic [3:0]    periph_be,
  input  logic [31:0]   periph_data,
  input  logic [ID-1:0] periph_id,
  output logic [31:0]   periph_r_data,
  output logic          periph_r_valid,
  output logic [ID-1:0] periph_r_id,
  output logic          csb2nvdla_valid,
  input  logic          csb2nvdla_ready,
  output logic [15:0]   csb2nvdla_addr,
  output logic [31:0]   csb2nvdla_wdat,
  output logic          csb2nvdla_write,
  output logic          csb2nvdla_nposted,
  input  logic          nvdla2csb_valid,
  input  logic [31:0]   nvdla2csb_data,
  output logic          err_o
);

  localparam int unsigned CntW = $clog2(RD_TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCsbReq, StWaitRd, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic            write_q, write_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [ID-1:0]   id_q, id_d;
  logic [31:0]     rdata_q, rdata_d;

  // CSB writes are full-word and only the word address reaches CSB.
  logic unused_in;
  assign unused_in = ^{periph_be, periph_add[31:18], periph_add[1:0]};

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    write_d         = write_q;
    wdat_d          = wdat_q;
    id_d            = id_q;
    rdata_d         = rdata_q;
    periph_gnt      = 1'b0;
    csb2nvdla_valid = 1'b0;
    periph_r_valid  = 1'b0;
    err_o           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (periph_req) begin
          periph_gnt = 1'b1;
          addr_d     = periph_add[17:2];
          write_d    = ~periph_wen;
          wdat_d     = periph_data;
          id_d       = periph_id;
          state_d    = StCsbReq;
        end
      end
      StCsbReq: begin
        csb2nvdla_valid = 1'b1;
        if (csb2nvdla_ready) begin
          cnt_d = '0;
          if (write_q) begin
            rdata_d = 32'h0;
            state_d = StResp;
          end else begin
            state_d = StWaitRd;
          end
        end
      end
      StWaitRd: begin
        // Real data takes priority over a timeout landing in the same cycle.
        if (nvdla2csb_valid) begin
          rdata_d = nvdla2csb_data;
          state_d = StResp;
        end else if (cnt_q == CntMax) begin
          rdata_d = ERR_DATA;
          err_o   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        periph_r_valid = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign csb2nvdla_addr    = addr_q;
  assign csb2nvdla_wdat    = wdat_q;
  assign csb2nvdla_write   = write_q;
  assign csb2nvdla_nposted = 1'b0;
  assign periph_r_data     = rdata_q;
  assign periph_r_id       = id_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdat_q  <= '0;
      id_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdat_q  <= wdat_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_nvdla_periph_csb_bridge.sv
// Randomized self-checking bench: the driver plays both periph master and CSB target
// and states the expected outputs per cycle; one monitor compares them at negedge.
module tb_nvdla_periph_csb_bridge;

  localparam int unsigned RdTo   = 8;
  localparam logic [31:0] ErrVal = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, wen, rv, cv, ready, wr, np, nv_valid, err;
  logic [31:0] add, wdata, rdata, caddr32, cwdat, nv_data;
  logic [3:0]  be;
  logic [9:0]  id, rid;
  logic [15:0] caddr;

  nvdla_periph_csb_bridge #(.ID(10), .RD_TIMEOUT(RdTo), .ERR_DATA(ErrVal)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .periph_req(req), .periph_gnt(gnt), .periph_add(add), .periph_wen(wen),
    .periph_be(be), .periph_data(wdata), .periph_id(id),
    .periph_r_data(rdata), .periph_r_valid(rv), .periph_r_id(rid),
    .csb2nvdla_valid(cv), .csb2nvdla_ready(ready), .csb2nvdla_addr(caddr),
    .csb2nvdla_wdat(cwdat), .csb2nvdla_write(wr), .csb2nvdla_nposted(np),
    .nvdla2csb_valid(nv_valid), .nvdla2csb_data(nv_data), .err_o(err)
  );

  always #5 clk = ~clk;
  assign caddr32 = {16'h0, caddr};

  int total = 0, bad = 0, cyc = 0;
  int gnt_cyc, hs_cyc, rv_cyc, err_cyc, err_cnt = 0;
  logic [31:0] last_rdata, last_wdat;
  logic [15:0] last_addr;
  logic [9:0]  last_rid;
  logic        last_write;

  // Expected outputs for the current cycle, set by the driver.
  logic        mon_en = 1'b0, e_rst, e_gnt, e_cv, e_write, e_rv, e_err;
  logic [15:0] e_addr;
  logic [31:0] e_wdat, e_rdata;
  logic [9:0]  e_rid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (e_rst) begin
        chk("rst_gnt", {31'h0, gnt}, 0);
        chk("rst_csb_valid", {31'h0, cv}, 0);
        chk("rst_addr", caddr32, 0);
        chk("rst_wdat", cwdat, 0);
        chk("rst_write", {31'h0, wr}, 0);
        chk("rst_r_valid", {31'h0, rv}, 0);
        chk("rst_r_data", rdata, 0);
        chk("rst_r_id", {22'h0, rid}, 0);
        chk("rst_err", {31'h0, err}, 0);
      end else begin
        chk("gnt", {31'h0, gnt}, {31'h0, e_gnt});
        chk("csb_valid", {31'h0, cv}, {31'h0, e_cv});
        if (e_cv) begin
          chk("csb_addr", caddr32, {16'h0, e_addr});
          chk("csb_wdat", cwdat, e_wdat);
          chk("csb_write", {31'h0, wr}, {31'h0, e_write});
        end
        chk("r_valid", {31'h0, rv}, {31'h0, e_rv});
        if (e_rv) begin
          chk("r_data", rdata, e_rdata);
          chk("r_id", {22'h0, rid}, {22'h0, e_rid});
        end
        chk("err_o", {31'h0, err}, {31'h0, e_err});
      end
      chk("nposted", {31'h0, np}, 0);
      if (gnt) gnt_cyc = cyc;
      if (cv && ready) hs_cyc = cyc;
      if (cv) begin
        last_addr  = caddr;
        last_wdat  = cwdat;
        last_write = wr;
      end
      if (rv) begin
        rv_cyc     = cyc;
        last_rdata = rdata;
        last_rid   = rid;
      end
      if (err) begin
        err_cyc = cyc;
        err_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    e_rst = 0; e_gnt = 0; e_cv = 0; e_rv = 0; e_err = 0;
  endtask

  // Busy-cycle periph activity that must never be granted or captured.
  task automatic rand_bus();
    req = 1'($urandom); add = $urandom; wen = 1'($urandom); wdata = $urandom;
    id = 10'($urandom); be = 4'($urandom);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      clr_exp(); req = 0; ready = 1'($urandom);
      nv_valid = 1'($urandom); nv_data = $urandom;
      tick();
    end
    nv_valid = 0;
  endtask

  // rd_dly: cycles after the CSB handshake at which read data arrives (>RdTo: never).
  task automatic txn(input bit rd, input logic [31:0] a, input logic [31:0] d,
                     input logic [9:0] i, input int rdy_dly, input int rd_dly,
                     input logic [31:0] rdv);
    logic [31:0] exp_d;
    clr_exp();
    req = 1; add = a; wen = rd; wdata = d; id = i; be = 4'($urandom);
    ready = 1'($urandom); nv_valid = 1'($urandom); nv_data = $urandom;
    e_gnt = 1;
    tick();
    for (int k = 0; k <= rdy_dly; k++) begin
      clr_exp(); rand_bus();
      ready = (k == rdy_dly); nv_valid = 1'($urandom); nv_data = $urandom;
      e_cv = 1; e_addr = a[17:2]; e_wdat = d; e_write = !rd;
      tick();
    end
    exp_d = 32'h0;
    if (rd) begin
      for (int dd = 1; dd <= int'(RdTo); dd++) begin
        clr_exp(); rand_bus(); ready = 1'($urandom);
        nv_valid = (dd == rd_dly); nv_data = nv_valid ? rdv : $urandom;
        if (dd == rd_dly) exp_d = rdv;
        else if (dd == int'(RdTo)) begin
          e_err = 1;
          exp_d = ErrVal;
        end
        tick();
        if (dd == rd_dly || dd == int'(RdTo)) break;
      end
    end
    clr_exp(); rand_bus(); nv_valid = 1'($urandom); nv_data = $urandom;
    e_rv = 1; e_rdata = exp_d; e_rid = i;
    tick();
    clr_exp(); req = 0; nv_valid = 0;
  endtask

  initial begin
    int e0;
    rst_n = 0; req = 0; add = 0; wen = 0; wdata = 0; id = 0; be = 0;
    ready = 0; nv_valid = 0; nv_data = 0;
    clr_exp();
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1; e_rst = 1;
    tick();
    rst_n = 1;
    tick();
    clr_exp();

    // Directed write.
    txn(0, 32'h0000_1008, 32'hA5A5_0001, 10'd3, 0, 0, 0);
    chk("lit_wr_addr", {16'h0, last_addr}, 32'h0000_0402);
    chk("lit_wr_wdat", last_wdat, 32'hA5A5_0001);
    chk("lit_wr_write", {31'h0, last_write}, 1);
    chk("lit_wr_rdata", last_rdata, 0);
    chk("lit_wr_rid", {22'h0, last_rid}, 3);
    chk("lit_wr_lat", rv_cyc - gnt_cyc, 2);

    // Directed read, data five cycles after handshake.
    e0 = err_cnt;
    txn(1, 32'h0000_0010, 32'h0, 10'd7, 0, 5, 32'h1234_5678);
    chk("lit_rd_rdata", last_rdata, 32'h1234_5678);
    chk("lit_rd_rid", {22'h0, last_rid}, 7);
    chk("lit_rd_noerr", err_cnt - e0, 0);
    chk("lit_rd_lat", rv_cyc - hs_cyc, 6);
    chk("lit_rd_addr", {16'h0, last_addr}, 32'h0000_0004);

    // Backpressure: ready low for 10 cycles.
    txn(0, 32'hFFFC_0020, 32'h0BAD_F00D, 10'd100, 10, 0, 0);
    chk("lit_bp_lat", rv_cyc - gnt_cyc, 12);
    chk("lit_bp_addr", {16'h0, last_addr}, 32'h0000_0008);

    // Timeout with no read data.
    idle(2);
    e0 = err_cnt;
    txn(1, 32'h0000_0040, 32'h0, 10'd9, 0, 100, 0);
    chk("lit_to_err", err_cnt - e0, 1);
    chk("lit_to_lat", err_cyc - hs_cyc, 8);
    chk("lit_to_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("lit_to_resp", rv_cyc - err_cyc, 1);

    // Data on the timeout cycle wins.
    e0 = err_cnt;
    txn(1, 32'h0000_0044, 32'h0, 10'd11, 0, int'(RdTo), 32'hCAFE_F00D);
    chk("lit_edge_rdata", last_rdata, 32'hCAFE_F00D);
    chk("lit_edge_noerr", err_cnt - e0, 0);

    // Reset during WAIT_RD aborts the read.
    clr_exp(); req = 1; add = 32'h80; wen = 1; id = 10'd21; e_gnt = 1;
    tick();
    clr_exp(); req = 0; ready = 1; e_cv = 1; e_addr = 16'h0020; e_wdat = wdata; e_write = 0;
    tick();
    clr_exp(); ready = 0;
    repeat (2) tick();
    rst_n = 0;
    tick();
    e_rst = 1;
    tick();
    rst_n = 1;
    tick();
    clr_exp();
    txn(1, 32'h0000_0084, 32'h0, 10'd22, 1, 2, 32'h5555_AAAA);
    chk("lit_post_rst_rdata", last_rdata, 32'h5555_AAAA);
    chk("lit_post_rst_rid", {22'h0, last_rid}, 22);

    // Random traffic, including back-to-back requests and timeouts.
    for (int n = 0; n < 200; n++) begin
      txn(1'($urandom), $urandom, $urandom, 10'($urandom), $urandom_range(0, 4),
          $urandom_range(1, 10), $urandom);
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
